// File: rtl/avg_seq_if.sv
// avg_seq stream bundle: sample stream in (s_*), result stream out (r_*).
interface avg_seq_if;
   logic        s_valid;
   logic        s_ready;
   logic [15:0] s_data;
   logic        r_valid;
   logic        r_ready;
   logic [15:0] r_data;

   modport master (
      output s_valid, s_data, r_ready,
      input  s_ready, r_valid, r_data
   );

   modport slave (
      input  s_valid, s_data, r_ready,
      output s_ready, r_valid, r_data
   );
endinterface

// File: rtl/avg_seq.sv
// avg_seq: gathers a 16-sample window, waits out the averager
// latency, then holds the returned average until it is taken.
module avg_seq #(
   parameter int AVG_LAT = 1,
   parameter int N_WIN   = 16
) (
   input  logic          clk,
   input  logic          rst_n,
   avg_seq_if.slave      bus,
   output logic [255:0]  win_data,
   input  logic [15:0]   avg_in,
   input  logic          clr,
   output logic          busy
);

   if (N_WIN != 16) begin : g_bad_nwin
      $error("avg_seq: N_WIN must be 16");
   end

   if (AVG_LAT < 1 || AVG_LAT > 15) begin : g_bad_lat
      $error("avg_seq: AVG_LAT must be 1..15");
   end

   localparam logic [3:0] LP_LAT = 4'(AVG_LAT);

   typedef enum logic [1:0] {
      S_FILL = 2'b00,
      S_WAIT = 2'b01,
      S_HOLD = 2'b10
   } state_t;

   state_t              r_state;
   state_t              w_state_nx;
   logic [3:0]          r_cnt;
   logic [3:0]          w_cnt_nx;
   logic [3:0]          r_lat;
   logic [3:0]          w_lat_nx;
   logic                r_rdy;
   logic [15:0]         r_res;
   logic [15:0][15:0]   r_win;
   logic                w_fill;
   logic                w_wait;
   logic                w_hold;
   logic                w_acc;
   logic                w_wr;
   logic                w_cap;

   assign w_fill = (r_state == S_FILL);
   assign w_wait = (r_state == S_WAIT);
   assign w_hold = (r_state == S_HOLD);

   // r_rdy keeps s_ready low until the first edge after reset
   assign bus.s_ready = r_rdy & w_fill;
   assign bus.r_valid = w_hold;
   assign bus.r_data  = r_res;
   assign win_data    = r_win;
   assign busy        = ~(w_fill & (r_cnt == 4'd0));
   assign w_acc       = r_rdy & w_fill & bus.s_valid;

   always_comb begin
      w_state_nx = r_state;
      w_cnt_nx   = r_cnt;
      w_lat_nx   = r_lat;
      w_wr       = 1'b0;
      w_cap      = 1'b0;
      if (clr) begin
         w_state_nx = S_FILL;
         w_cnt_nx   = 4'd0;
         w_lat_nx   = 4'd0;
      end else begin
         unique case (1'b1)
            w_fill: begin
               if (w_acc) begin
                  w_wr     = 1'b1;
                  w_cnt_nx = r_cnt + 4'd1;
                  if (r_cnt == 4'd15) begin
                     w_state_nx = S_WAIT;
                     w_lat_nx   = LP_LAT;
                  end
               end
            end
            w_wait: begin
               w_lat_nx = r_lat - 4'd1;
               if (r_lat <= 4'd1) begin
                  w_cap      = 1'b1;
                  w_lat_nx   = 4'd0;
                  w_state_nx = S_HOLD;
               end
            end
            w_hold: begin
               if (bus.r_ready) begin
                  w_state_nx = S_FILL;
               end
            end
            default: begin
               w_state_nx = S_FILL;
               w_cnt_nx   = 4'd0;
               w_lat_nx   = 4'd0;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_FILL;
         r_cnt   <= 4'd0;
         r_lat   <= 4'd0;
         r_rdy   <= 1'b0;
      end else begin
         r_state <= w_state_nx;
         r_cnt   <= w_cnt_nx;
         r_lat   <= w_lat_nx;
         r_rdy   <= 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_res <= 16'd0;
         r_win <= '0;
      end else begin
         if (w_cap) begin
            r_res <= avg_in;
         end
         if (w_wr) begin
            r_win[r_cnt] <= bus.s_data;
         end
      end
   end

endmodule

// File: doc/avg_seq.md
AVG_SEQ -- requirements
Module: avg_seq

Interface
REQ-001 SHALL provide parameter AVG_LAT, default 1, meaning the clock cycles from a stable window on win_data to a valid avg_in (legal range 1..15).
REQ-002 SHALL provide parameter N_WIN, default 16, meaning samples per window; fixed at 16, and any other value is a synthesis error.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-005 SHALL have port s_valid, input, 1 bit: the upstream sample is valid.
REQ-006 SHALL have port s_ready, output, 1 bit: the block accepts a sample this cycle.
REQ-007 SHALL have port s_data, input, 16 bits: the upstream sample, unsigned.
REQ-008 SHALL have port win_data, output, 256 bits: window to the averager datapath; bits [16k+15:16k] carry sample k, where k=0 is the first accepted sample.
REQ-009 SHALL have port avg_in, input, 16 bits: registered average returned by the averager datapath.
REQ-010 SHALL have port r_valid, output, 1 bit: a result is held on r_data.
REQ-011 SHALL have port r_ready, input, 1 bit: the downstream consumer takes the result.
REQ-012 SHALL have port r_data, output, 16 bits: captured average.
REQ-013 SHALL have port clr, input, 1 bit: synchronous abort of the current window.
REQ-014 SHALL have port busy, output, 1 bit: high in any state other than FILL with cnt=0.

Function
REQ-015 SHALL implement three states: FILL, WAIT and HOLD.
REQ-016 In FILL: s_ready=1; a sample is accepted when s_valid&s_ready, written to slot cnt, and cnt is incremented by 1 (cnt is 4 bits).
REQ-017 The 16th acceptance (cnt=15) SHALL move FILL to WAIT, set cnt=0 and load the latency counter lat=AVG_LAT.
REQ-018 In WAIT: s_ready=0; lat decrements by 1 each cycle; when lat=1 the next edge SHALL capture avg_in into r_data and move to HOLD.
REQ-019 win_data SHALL remain unchanged throughout WAIT and HOLD; slots written in FILL SHALL not change until overwritten in the next window.
REQ-020 In HOLD: r_valid=1 and s_ready=0; r_data is stable until r_valid&r_ready.
REQ-021 The r_valid&r_ready handshake SHALL move HOLD to FILL and drop r_valid on the next cycle.
REQ-022 Total latency from 16th acceptance to r_valid=1 SHALL be AVG_LAT+1 cycles.
REQ-023 s_ready and r_valid SHALL be driven from registered state only, with no combinational path from s_valid or r_ready.
REQ-024 A sample offered while s_ready=0 SHALL not be consumed; upstream must hold it.
REQ-025 clr=1 SHALL force FILL with cnt=0, r_valid=0 and lat=0 on the next edge, in any state, with priority over every other event that cycle.
REQ-026 A sample presented in the same cycle as clr=1 SHALL be discarded and SHALL not be written.
REQ-027 On clr, win_data contents SHALL be retained, not zeroed.
REQ-028 With r_ready held high in HOLD, the block SHALL spend exactly one cycle in HOLD.
REQ-029 The state register SHALL use safe encoding: an illegal code returns to FILL, cnt=0.

Reset
REQ-030 rst_n=0 SHALL asynchronously force state=FILL, cnt=0, lat=0, r_valid=0, r_data=0, all win_data slots=0 and busy=0.
REQ-031 While rst_n=0, s_ready SHALL be 0; s_ready SHALL rise on the first clk edge after rst_n deasserts.
REQ-032 Reset asserted mid-WAIT or mid-HOLD SHALL discard the pending window and result with no r_valid pulse.

Verification
REQ-033 Stream 16 samples 0x0001..0x0010 back-to-back, stub avg_in=0x0008, AVG_LAT=1 -> s_ready low after the 16th sample, r_valid high 2 cycles later, r_data=0x0008, win_data slot0=0x0001 and slot15=0x0010.
REQ-034 Hold r_ready=0 for 5 cycles in HOLD while avg_in changes to 0xFFFF -> r_data stays 0x0008, s_valid samples not accepted, and after the handshake the next window's sample lands in slot0.
REQ-035 Assert clr with s_valid=1 after 7 samples -> sample discarded, cnt=0, and the next 16 samples form a full window with r_valid only after those 16.
REQ-036 Pulse rst_n low asynchronously mid-WAIT, between clk edges -> r_valid=0, r_data=0x0000 and win_data all zero immediately; no result appears afterwards.
REQ-037 Apply random s_valid/r_ready throttling over 100 windows, AVG_LAT=3 -> every result is captured exactly AVG_LAT+1 cycles after its 16th sample, with no samples lost or duplicated (scoreboard).
